image_stream_sender: RTL and testbench

Transmit-side counterpart of the Sobel stream input. It reads a stored greyscale frame from a synchronous-read frame buffer and emits it as the byte stream the Sobel stage consumes. The stream is a 4-byte little-endian header (width, height) followed by width×height pixel bytes in raster order. It drives a valid/ready byte interface toward either the Sobel stage or the UART transmitter, with an optional minimum inter-byte gap for pacing.

---
 rtl/image_stream_sender.sv | 179 +++++++++++++++++
 tb/tb_image_stream_sender.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_sender.sv
// image_stream_sender
// Reads a stored greyscale frame from a synchronous-read frame buffer and
// emits it as a byte stream: a 4-byte little-endian header (width, height)
// followed by width*height pixel bytes in raster order.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   start               request one frame (sampled only while idle)
//   width, height       frame dimensions, latched when start is accepted
//   mem_addr, mem_rd_en frame buffer read port (data returns one cycle later)
//   mem_data            frame buffer read data
//   data_out, valid_out stream byte and its valid flag
//   ready_in            downstream ready; a byte moves when valid && ready
//   busy                a frame is in progress
//   done                one-cycle pulse after the final byte is accepted
//   error               one-cycle pulse when start is rejected as oversize
module image_stream_sender #(
  parameter int DATA_BITS  = 8,
  parameter int ADDR_BITS  = 12,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          width,
  input  logic [15:0]          height,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [DATA_BITS-1:0] mem_data,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    IDLE, HEADER, FETCH, LOAD, SEND, GAP, DONE
  } state_t;

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_BITS;
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [31:0] GAP_LAST = HAS_GAP ? 32'(GAP_CYCLES - 1) : 32'd0;

  state_t      state, next_state, gap_ret;
  logic [15:0] width_q, height_q;
  logic [31:0] pix_total, pix_idx, gap_cnt, start_total;
  logic [1:0]  hdr_idx, hdr_sel;
  logic [7:0]  hdr_byte;
  logic        oversize, xfer, last_hdr, last_pix, gap_end;

  // Frame size seen on the live inputs, used only at start acceptance.
  // The 33-bit compare keeps a 2^32-ish product from aliasing below capacity.
  assign start_total = {16'd0, width} * {16'd0, height};
  assign oversize    = {1'b0, start_total} > CAPACITY;

  assign xfer     = valid_out && ready_in;
  assign last_hdr = (hdr_idx == 2'd3);
  assign last_pix = (pix_idx == pix_total - 32'd1);
  assign gap_end  = (gap_cnt == GAP_LAST);
  assign mem_addr = pix_idx[ADDR_BITS-1:0];

  // Header byte selection. While a header byte is being accepted the next
  // byte is loaded straight away, so look one index ahead; coming out of a
  // gap the index has already advanced.
  always_comb begin
    hdr_sel = (state == HEADER) ? hdr_idx + 2'd1 : hdr_idx;
    unique case (hdr_sel)
      2'd0:    hdr_byte = width_q[7:0];
      2'd1:    hdr_byte = width_q[15:8];
      2'd2:    hdr_byte = height_q[7:0];
      default: hdr_byte = height_q[15:8];
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. A gap is taken after every accepted byte except the
  // last one of the frame, and resumes wherever gap_ret points.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (start && !oversize) next_state = HEADER;
      HEADER: if (xfer) begin
                if (last_hdr && pix_total == 32'd0) next_state = DONE;
                else if (HAS_GAP)                   next_state = GAP;
                else if (last_hdr)                  next_state = FETCH;
              end
      FETCH:  next_state = LOAD;
      LOAD:   next_state = SEND;
      SEND:   if (xfer) begin
                if (last_pix)     next_state = DONE;
                else if (HAS_GAP) next_state = GAP;
                else              next_state = FETCH;
              end
      GAP:    if (gap_end) next_state = gap_ret;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded directly from state so they clear with the reset.
  always_comb begin
    mem_rd_en = (state == FETCH);
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
  end

  // Datapath: latched frame parameters, counters and the registered stream
  // byte. valid_out only drops on a transfer, which keeps the handshake
  // stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q   <= '0;
      height_q  <= '0;
      pix_total <= '0;
      pix_idx   <= '0;
      gap_cnt   <= '0;
      hdr_idx   <= '0;
      gap_ret   <= IDLE;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      error <= 1'b0;
      if (state != GAP && next_state == GAP)
        gap_ret <= (state == HEADER && !last_hdr) ? HEADER : FETCH;
      unique case (state)
        IDLE: if (start) begin
                if (oversize) begin
                  error <= 1'b1;
                end else begin
                  width_q   <= width;
                  height_q  <= height;
                  pix_total <= start_total;
                  pix_idx   <= '0;
                  hdr_idx   <= '0;
                  gap_cnt   <= '0;
                  data_out  <= width[7:0];
                  valid_out <= 1'b1;
                end
              end
        HEADER: if (xfer) begin
                  if (last_hdr) begin
                    valid_out <= 1'b0;
                  end else begin
                    hdr_idx <= hdr_idx + 2'd1;
                    if (HAS_GAP) valid_out <= 1'b0;
                    else         data_out  <= hdr_byte;
                  end
                end
        GAP: if (gap_end) begin
               gap_cnt <= '0;
               if (gap_ret == HEADER) begin
                 data_out  <= hdr_byte;
                 valid_out <= 1'b1;
               end
             end else begin
               gap_cnt <= gap_cnt + 32'd1;
             end
        LOAD: begin
                data_out  <= mem_data;
                valid_out <= 1'b1;
              end
        SEND: if (xfer) begin
                valid_out <= 1'b0;
                pix_idx   <= pix_idx + 32'd1;
              end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_sender.sv
// tb_image_stream_sender
// Drives two senders (no pacing, and a 3-cycle gap) from a shared frame
// buffer model. Each frame's expected byte stream is built from the header
// layout and the buffer contents, then compared with what was accepted.
module tb_image_stream_sender;

  logic        clk, rst, start, sel, ready;
  logic [15:0] width, height;
  logic [7:0]  mem [0:4095];

  logic [11:0] a_addr, b_addr;
  logic        a_rd_en, b_rd_en, a_valid, b_valid, a_busy, b_busy;
  logic        a_done, b_done, a_error, b_error, a_start, b_start;
  logic [7:0]  a_mem_data, b_mem_data, a_data, b_data;

  logic        obs_valid, obs_busy, obs_done, obs_error, obs_rd_en;
  logic [7:0]  obs_data;

  int compared = 0;
  int mismatched = 0;

  assign a_start   = start & ~sel;
  assign b_start   = start & sel;
  assign obs_valid = sel ? b_valid : a_valid;
  assign obs_busy  = sel ? b_busy  : a_busy;
  assign obs_done  = sel ? b_done  : a_done;
  assign obs_error = sel ? b_error : a_error;
  assign obs_rd_en = sel ? b_rd_en : a_rd_en;
  assign obs_data  = sel ? b_data  : a_data;

  image_stream_sender #(.DATA_BITS(8), .ADDR_BITS(12), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .width(width), .height(height),
    .mem_addr(a_addr), .mem_rd_en(a_rd_en), .mem_data(a_mem_data),
    .data_out(a_data), .valid_out(a_valid), .ready_in(ready),
    .busy(a_busy), .done(a_done), .error(a_error));

  image_stream_sender #(.DATA_BITS(8), .ADDR_BITS(12), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .width(width), .height(height),
    .mem_addr(b_addr), .mem_rd_en(b_rd_en), .mem_data(b_mem_data),
    .data_out(b_data), .valid_out(b_valid), .ready_in(ready),
    .busy(b_busy), .done(b_done), .error(b_error));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read frame buffers: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (a_rd_en) a_mem_data <= mem[a_addr];
    if (b_rd_en) b_mem_data <= mem[b_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Runs one frame. mode 0: ready always high, 1: ready pattern 1,0,0,1,
  // 2: random ready plus junk start/width/height while busy.
  task automatic applyStimulus(input logic [15:0] w, input logic [15:0] h,
                               input int mode, input logic use_b,
                               input string name);
    logic [7:0] expq[$];
    logic [7:0] got[$];
    int unsigned total;
    int budget, reads, stall_err, idle, min_idle, n;
    logic done_seen, prev_stall, r;
    logic [7:0] prev_data;

    total = w * h;
    expq.push_back(w[7:0]);
    expq.push_back(w[15:8]);
    expq.push_back(h[7:0]);
    expq.push_back(h[15:8]);
    for (int k = 0; k < int'(total); k++) expq.push_back(mem[k]);

    budget = 16 * (int'(total) + 4) + 40;
    reads = 0; stall_err = 0; idle = 0; min_idle = 1000;
    done_seen = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;

    sel = use_b;
    @(negedge clk);
    start = 1'b1; width = w; height = h; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, "_busy_start"}, 32'(obs_busy), 32'd1);
    checkOutput({name, "_valid_start"}, 32'(obs_valid), 32'd1);

    for (int cyc = 0; cyc < budget; cyc++) begin
      if (prev_stall && (!obs_valid || obs_data !== prev_data)) stall_err++;
      if (obs_rd_en) reads++;
      if (obs_done) begin
        done_seen = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        checkOutput({name, "_busy_at_done"}, 32'(obs_busy), 32'd0);
        break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ready = r;
      if (mode == 2) begin
        start  = 1'($urandom_range(0, 1));
        width  = 16'($urandom);
        height = 16'($urandom);
      end
      if (obs_valid && r) begin
        got.push_back(obs_data);
        if (got.size() > 1 && idle < min_idle) min_idle = idle;
        idle = 0;
      end else if (!obs_valid) begin
        idle++;
      end
      prev_stall = obs_valid && !r;
      prev_data  = obs_data;
      @(negedge clk);
    end
    start = 1'b0;

    if (!done_seen) begin
      checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      checkOutput({name, "_done_pulse"}, 32'(obs_done), 32'd0);
      checkOutput({name, "_valid_after"}, 32'(obs_valid), 32'd0);
    end

    checkOutput({name, "_byte_count"}, 32'(got.size()), 32'(expq.size()));
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(expq[i]));
    checkOutput({name, "_reads"}, 32'(reads), total);
    checkOutput({name, "_stall_hold"}, 32'(stall_err), 32'd0);
    if (use_b)
      checkOutput({name, "_min_gap_ge3"}, 32'(min_idle >= 3), 32'd1);
  endtask

  task automatic applyOversize(input logic [15:0] w, input logic [15:0] h,
                               input string name);
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; width = w; height = h; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({name, "_error"}, 32'(obs_error), 32'd1);
    checkOutput({name, "_busy"}, 32'(obs_busy), 32'd0);
    checkOutput({name, "_valid"}, 32'(obs_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, "_error_clr"}, 32'(obs_error), 32'd0);
    checkOutput({name, "_busy2"}, 32'(obs_busy), 32'd0);
    checkOutput({name, "_valid2"}, 32'(obs_valid), 32'd0);
    ready = 1'b0;
  endtask

  initial begin
    int hx;
    logic found;

    rst = 1'b1; start = 1'b0; sel = 1'b0; ready = 1'b0;
    width = '0; height = '0;
    #12;
    checkOutput("reset_valid", 32'(a_valid), 32'd0);
    checkOutput("reset_data", 32'(a_data), 32'd0);
    checkOutput("reset_busy", 32'(a_busy | b_busy), 32'd0);
    checkOutput("reset_rd_en", 32'(a_rd_en), 32'd0);
    checkOutput("reset_addr", 32'(a_addr), 32'd0);
    checkOutput("reset_flags", 32'({a_done, a_error}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 4096; k++) mem[k] = 8'(k + 8'h10);
    applyStimulus(16'd4, 16'd3, 0, 1'b0, "f4x3");

    for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);
    applyStimulus(16'd2, 16'd2, 1, 1'b0, "bp2x2");

    applyOversize(16'd65, 16'd64, "over65x64");
    applyOversize(16'd1, 16'd4097, "over1x4097");

    applyStimulus(16'd0, 16'd5, 0, 1'b0, "zero0x5");
    applyStimulus(16'd1, 16'd1, 0, 1'b1, "pace1x1");
    applyStimulus(16'd2, 16'd3, 2, 1'b1, "pace2x3");

    // Reset while pixel 0 is waiting for ready.
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; width = 16'd2; height = 16'd2;
    @(negedge clk);
    start = 1'b0; ready = 1'b1;
    hx = 0; found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (obs_valid && hx == 4) begin
        found = 1'b1;
        ready = 1'b0;
        break;
      end
      if (obs_valid && ready) hx++;
      @(negedge clk);
    end
    checkOutput("rst_reach_send", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(a_valid), 32'd0);
    checkOutput("rst_data", 32'(a_data), 32'd0);
    checkOutput("rst_busy", 32'(a_busy), 32'd0);
    checkOutput("rst_rd_addr", 32'({a_rd_en, a_addr}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'd1, 16'd1, 0, 1'b0, "after_rst");

    for (int t = 0; t < 6; t++) begin
      logic [15:0] w, h;
      int m;
      for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);
      w = 16'($urandom_range(0, 12));
      h = 16'($urandom_range(0, 12));
      m = $urandom_range(0, 2);
      applyStimulus(w, h, m, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
